// File: rtl/stencil_pkg.sv
// Shared helpers for the stencil window generator: counter widths, the default
// pixel type and the window slot mapping.
package stencil_pkg;

  localparam int PIX_W_DEF = 16;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  function automatic int col_w(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_w(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

  // Slot 0 is the top-left pixel; rows of the window are laid out contiguously.
  function automatic int win_slot(input int y, input int x, input int k);
    return y * k + x;
  endfunction

endpackage

// File: rtl/stencil_row_ram.sv
// Line buffer holding the K-1 previous rows per column; asynchronous read so the
// old column is available in the same cycle it is overwritten.
module stencil_row_ram
  import stencil_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 64,
  parameter int ADDR_W = col_w(IMG_W)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [(K-1)*WIDTH-1:0]   wdata_i,
  output logic [(K-1)*WIDTH-1:0]   rdata_o
);

  logic [(K-1)*WIDTH-1:0] mem_q [IMG_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/stencil_window_ub.sv
// Streaming KxK stencil window generator with valid/ready flow control; windows
// are emitted only when they lie fully inside the image.
module stencil_window_ub
  import stencil_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [K*K*WIDTH-1:0]   out_data,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int COL_W = col_w(IMG_W);
  localparam int ROW_W = row_w(IMG_H);
  localparam int LW    = (K-1)*WIDTH;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W-1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H-1);

  typedef logic [WIDTH-1:0] pix_t;

  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [K*K*WIDTH-1:0]   out_data_q, out_data_d;
  pix_t                   win_q [K][K];
  pix_t                   win_d [K][K];
  pix_t                   colv  [K];
  logic [LW-1:0]          ram_rd, ram_wr;
  logic [K*K*WIDTH-1:0]   win_flat;
  logic                   acc, emit, frame_end;

  assign in_ready  = out_ready || !out_valid_q;
  assign acc       = in_valid && in_ready;
  assign emit      = (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
  assign frame_end = (row_q == ROW_MAX) && (col_q == COL_MAX);

  stencil_row_ram #(
    .WIDTH  (WIDTH),
    .K      (K),
    .IMG_W  (IMG_W),
    .ADDR_W (COL_W)
  ) u_row_ram (
    .clk_i   (clk),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (ram_wr),
    .rdata_o (ram_rd)
  );

  // Column vector: oldest row on top, the incoming pixel at the bottom; the
  // RAM word ages by one row on every write.
  always_comb begin
    for (int y = 0; y < K; y++) colv[y] = '0;
    for (int y = 0; y < K-1; y++) colv[y] = ram_rd[(K-2-y)*WIDTH +: WIDTH];
    colv[K-1] = in_data;
    ram_wr = '0;
    ram_wr[0 +: WIDTH] = in_data;
    for (int j = 1; j < K-1; j++) ram_wr[j*WIDTH +: WIDTH] = ram_rd[(j-1)*WIDTH +: WIDTH];
  end

  always_comb begin
    for (int y = 0; y < K; y++) begin
      for (int x = 0; x < K; x++) win_d[y][x] = win_q[y][x];
    end
    if (acc) begin
      for (int y = 0; y < K; y++) begin
        for (int x = 0; x < K-1; x++) win_d[y][x] = win_q[y][x+1];
        win_d[y][K-1] = colv[y];
      end
    end
    win_flat = '0;
    for (int y = 0; y < K; y++) begin
      for (int x = 0; x < K; x++) win_flat[win_slot(y, x, K)*WIDTH +: WIDTH] = win_d[y][x];
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (acc) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      out_valid_d = emit;
      out_last_d  = emit && frame_end;
      if (emit) out_data_d = win_flat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Window shift register carries data only; stale columns are masked by the guards.
  always_ff @(posedge clk) begin
    for (int y = 0; y < K; y++) begin
      for (int x = 0; x < K; x++) win_q[y][x] <= win_d[y][x];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_stencil_window_ub.sv
// Scoreboard bench for stencil_window_ub: a 3x3/4x4 instance for the main
// scenarios and a 5x5 instance on an 8x6 image.
module tb_stencil_window_ub;

  localparam int AW = 16, AK = 3, AIW = 4, AIH = 4;
  localparam int ADW = AK*AK*AW;
  localparam int BW = 8, BK = 5, BIW = 8, BIH = 6;
  localparam int BDW = BK*BK*BW;

  localparam logic [ADW-1:0] A_FIRST = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
  localparam logic [ADW-1:0] A_LAST  = {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_ready;
  logic [AW-1:0]  a_in_data;
  logic [ADW-1:0] a_out_data;
  logic           rst_b, b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready;
  logic [BW-1:0]  b_in_data;
  logic [BDW-1:0] b_out_data;

  stencil_window_ub #(.WIDTH(AW), .K(AK), .IMG_W(AIW), .IMG_H(AIH)) dut_a (
    .clk(clk), .reset(rst_a), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last), .out_ready(a_out_ready));

  stencil_window_ub #(.WIDTH(BW), .K(BK), .IMG_W(BIW), .IMG_H(BIH)) dut_b (
    .clk(clk), .reset(rst_b), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last), .out_ready(b_out_ready));

  int checks = 0;
  int errors = 0;
  int a_pops = 0;
  int b_pops = 0;
  bit rand_rdy = 1'b0;
  logic [ADW-1:0] qa_data [$];
  logic           qa_last [$];
  logic [BDW-1:0] qb_data [$];
  logic           qb_last [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ADW-1:0] exp_a(input int r, input int c);
    logic [ADW-1:0] w = '0;
    for (int y = 0; y < AK; y++)
      for (int x = 0; x < AK; x++)
        w[(y*AK + x)*AW +: AW] = AW'((r-AK+1+y)*AIW + (c-AK+1+x));
    return w;
  endfunction

  function automatic logic [BDW-1:0] exp_b(input int r, input int c);
    logic [BDW-1:0] w = '0;
    for (int y = 0; y < BK; y++)
      for (int x = 0; x < BK; x++)
        w[(y*BK + x)*BW +: BW] = BW'((r-BK+1+y)*BIW + (c-BK+1+x));
    return w;
  endfunction

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_pops++;
      if (qa_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_window: got %0h expected none", a_out_data);
      end else begin
        chk("a_window", a_out_data, qa_data.pop_front());
        chk("a_last", a_out_last, qa_last.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      b_pops++;
      if (qb_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_window: got %0h expected none", b_out_data);
      end else begin
        chk("b_window", b_out_data, qb_data.pop_front());
        chk("b_last", b_out_last, qb_last.pop_front());
      end
      if (b_out_last) chk("b_slot24", b_out_data[24*BW +: BW], 256'd47);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      a_out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_a(input int r, input int c, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 1)) begin a_in_valid = 1'b0; @(posedge clk); #1; end
    a_in_valid = 1'b1;
    a_in_data  = AW'(r*AIW + c);
    while (1) begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL a_accept_timeout: got no in_ready expected accept of pixel %0d", r*AIW + c);
        a_in_valid = 1'b0;
        return;
      end
    end
    if (r >= AK-1 && c >= AK-1) begin
      qa_data.push_back(exp_a(r, c));
      qa_last.push_back(r == AIH-1 && c == AIW-1);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic frame_a(input bit gaps, input bit lat, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_a(i / AIW, i % AIW, gaps);
      if (lat) begin
        chk("a_valid_lat", a_out_valid, 256'((i/AIW >= AK-1) && (i%AIW >= AK-1)));
        if (i == 10) chk("a_first_window", a_out_data, A_FIRST);
        if (i == 15) begin
          chk("a_last_window", a_out_data, A_LAST);
          chk("a_last_flag", a_out_last, 256'd1);
        end
      end
    end
  endtask

  task automatic drain_a(input string name);
    @(negedge clk);
    rand_rdy    = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk(name, qa_data.size(), 256'd0);
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    chk("reset_out_valid", a_out_valid, 256'd0);
    chk("reset_out_last", a_out_last, 256'd0);
    chk("reset_out_data", a_out_data, 256'd0);
    chk("reset_in_ready", a_in_ready, 256'd1);

    // Scenarios 1 and 2: full-rate frame, latency and column guard.
    frame_a(1'b0, 1'b1, AIW*AIH);
    drain_a("s1_drained");

    // Scenario 3: downstream stall with a window pending.
    frame_a(1'b0, 1'b0, 11);
    chk("s3_pending", a_out_valid, 256'd1);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = AW'(11);
    repeat (3) begin
      @(negedge clk);
      chk("s3_in_ready_low", a_in_ready, 256'd0);
      chk("s3_data_stable", a_out_data, A_FIRST);
      chk("s3_valid_hold", a_out_valid, 256'd1);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int i = 11; i < AIW*AIH; i++) send_a(i / AIW, i % AIW, 1'b0);
    drain_a("s3_drained");

    // Scenario 4: random gaps and back-pressure over three frames.
    @(posedge clk); #1;
    rand_rdy = 1'b1;
    repeat (3) frame_a(1'b1, 1'b0, AIW*AIH);
    drain_a("s4_drained");

    // Scenario 5: reset after pixel 9, then a clean frame.
    frame_a(1'b0, 1'b0, 10);
    pulse_reset_a();
    chk("s5_valid_after_reset", a_out_valid, 256'd0);
    chk("s5_ready_after_reset", a_in_ready, 256'd1);
    frame_a(1'b0, 1'b1, AIW*AIH);
    drain_a("s5_drained");

    // Pending window dropped by reset.
    frame_a(1'b0, 1'b0, 10);
    a_out_ready = 1'b0;
    send_a(2, 2, 1'b0);
    chk("drop_pending", a_out_valid, 256'd1);
    pulse_reset_a();
    void'(qa_data.pop_back());
    void'(qa_last.pop_back());
    chk("drop_valid_cleared", a_out_valid, 256'd0);
    chk("drop_ready", a_in_ready, 256'd1);
    a_out_ready = 1'b1;
    frame_a(1'b0, 1'b1, AIW*AIH);
    drain_a("drop_drained");
    chk("a_window_count", a_pops, 256'd28);

    // Scenario 6: 5x5 window on an 8x6 image.
    for (int i = 0; i < BIW*BIH; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = BW'(i);
      n = 0;
      while (1) begin
        @(negedge clk);
        if (b_in_ready || n > 50) break;
        n++;
      end
      chk("b_in_ready", b_in_ready, 256'd1);
      if (i/BIW >= BK-1 && i%BIW >= BK-1) begin
        qb_data.push_back(exp_b(i/BIW, i%BIW));
        qb_last.push_back(i == BIW*BIH-1);
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b_drained", qb_data.size(), 256'd0);
    chk("b_window_count", b_pops, 256'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
